// File: rtl/router_pkg.sv
// router_pkg: shared arbiter state type, routing-header TID and one-hot helper for the cut-through router
package router_pkg;
  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;
  localparam logic [3:0] ROUTING_HEADER = 4'hF;
  function automatic logic [4:0] onehot_to_idx(input logic [31:0] oh);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++) if (oh[i]) idx = 5'(i);
    return idx;
  endfunction
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin pick of the first candidate at or after rr_ptr
module rr_picker #(
  parameter int N  = 5,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  candidates,
  input  logic [IW-1:0] rr_ptr,
  output logic [N-1:0]  pick,
  output logic          valid
);
  logic [N-1:0] rot, low;
  // rotate so rr_ptr lands on bit 0, isolate lowest set bit, rotate back
  assign rot   = N'({candidates, candidates} >> rr_ptr);
  assign low   = rot & (~rot + N'(1));
  assign pick  = N'(({low, low} << rr_ptr) >> N);
  assign valid = |candidates;
endmodule

// File: rtl/cuthrough_output_arbiter.sv
// cuthrough_output_arbiter: per-output packet-locked round-robin AXI-Stream arbiter; ARB_PKT_CNT_EN adds per-channel packet counters
module cuthrough_output_arbiter
  import router_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 4,
  parameter int CHANNEL_NUMBER = 5,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [CHANNEL_NUMBER-1:0]          req,
  input  logic [CHANNEL_NUMBER-1:0]          s_tvalid,
  input  logic [CHANNEL_NUMBER*DATA_WIDTH-1:0] s_tdata,
  input  logic [CHANNEL_NUMBER*ID_WIDTH-1:0] s_tid,
  input  logic [CHANNEL_NUMBER-1:0]          s_tlast,
  output logic [CHANNEL_NUMBER-1:0]          s_tready,
  output logic                               m_tvalid,
  output logic [DATA_WIDTH-1:0]              m_tdata,
  output logic [ID_WIDTH-1:0]                m_tid,
  output logic                               m_tlast,
  input  logic                               m_tready,
  output logic [CHANNEL_NUMBER-1:0]          grant,
  output logic                               busy
`ifdef ARB_PKT_CNT_EN
  ,output logic [CHANNEL_NUMBER*CNT_WIDTH-1:0] pkt_cnt
`endif
);
  localparam int N     = CHANNEL_NUMBER;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  typedef logic [CNT_WIDTH-1:0] cnt_t;
  arb_state_t state_q, state_d;
  logic [N-1:0] grant_q, grant_d, pick;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d, owner;
  logic pick_valid, release_hs;
  rr_picker #(.N(N), .IW(IDX_W)) u_picker (
    .candidates(req & s_tvalid),
    .rr_ptr    (rr_ptr_q),
    .pick      (pick),
    .valid     (pick_valid)
  );
  assign owner      = IDX_W'(onehot_to_idx(32'(grant_q)));
  assign release_hs = m_tvalid & m_tready & m_tlast;
  assign s_tready   = grant_q & {N{m_tready}};
  assign grant      = grant_q;
  assign busy       = state_q == ARB_LOCKED;
  // grant_q is all-zero when idle, so the mux naturally drives zeros
  always_comb begin
    m_tvalid = 1'b0;
    m_tdata  = '0;
    m_tid    = '0;
    m_tlast  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grant_q[i]) begin
        m_tvalid = s_tvalid[i];
        m_tdata  = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        m_tid    = s_tid[i*ID_WIDTH +: ID_WIDTH];
        m_tlast  = s_tlast[i];
      end
    end
  end
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    if (state_q == ARB_IDLE && pick_valid) begin
      state_d = ARB_LOCKED;
      grant_d = pick;
    end
    if (state_q == ARB_LOCKED && release_hs) begin
      state_d  = ARB_IDLE;
      grant_d  = '0;
      rr_ptr_d = (32'(owner) == N - 1) ? '0 : owner + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
`ifdef ARB_PKT_CNT_EN
  cnt_t [N-1:0] pkt_cnt_q, pkt_cnt_d;
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    for (int i = 0; i < N; i++)
      if (release_hs && grant_q[i] && pkt_cnt_q[i] != '1) pkt_cnt_d[i] = pkt_cnt_q[i] + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) pkt_cnt_q <= '0;
    else pkt_cnt_q <= pkt_cnt_d;
  end
  assign pkt_cnt = pkt_cnt_q;
`endif
endmodule

// File: tb/tb_cuthrough_output_arbiter.sv
// tb_cuthrough_output_arbiter: directed and randomized checks against a round-robin packet model
module tb_cuthrough_output_arbiter;
  localparam int N  = 5;
  localparam int DW = 32;
  localparam int IW = 4;
`ifdef ARB_PKT_CNT_EN
  localparam int CW = 2;
`else
  localparam int CW = 16;
`endif
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req = '0, s_tvalid = '0, s_tlast = '0, s_tready, grant;
  logic [N*DW-1:0] s_tdata = '0;
  logic [N*IW-1:0] s_tid = '0;
  logic m_tvalid, m_tlast, busy;
  logic m_tready = 1'b0;
  logic [DW-1:0] m_tdata;
  logic [IW-1:0] m_tid;
`ifdef ARB_PKT_CNT_EN
  logic [N*CW-1:0] pkt_cnt;
`endif
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  cuthrough_output_arbiter #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .CHANNEL_NUMBER(N), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tid(s_tid),
    .s_tlast(s_tlast), .s_tready(s_tready), .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tid(m_tid),
    .m_tlast(m_tlast), .m_tready(m_tready), .grant(grant), .busy(busy)
`ifdef ARB_PKT_CNT_EN
    , .pkt_cnt(pkt_cnt)
`endif
  );
  // reference model: owner index (-1 when idle), search start, completed packets
  int mo, mp;
  int mc [N];
  logic [N-1:0] hs;
  function automatic int rr_pick(int ptr, logic [N-1:0] c);
    for (int k = 0; k < N; k++) if (c[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction
  always @(posedge clk) begin
    hs <= rst_n ? (s_tvalid & s_tready) : '0;
    if (!rst_n) begin
      mo <= -1;
      mp <= 0;
      for (int c = 0; c < N; c++) mc[c] <= 0;
    end else if (mo < 0) mo <= rr_pick(mp, req & s_tvalid);
    else if (s_tvalid[mo] && m_tready && s_tlast[mo]) begin
      mo <= -1;
      mp <= (mo + 1) % N;
      if (mc[mo] < CMAX) mc[mo] <= mc[mo] + 1;
    end
  end
  function automatic logic [N-1:0] exp_grant();
    return (mo < 0) ? '0 : N'(1 << mo);
  endfunction
  function automatic logic [DW-1:0] exp_data();
    if (mo < 0) return '0;
    return s_tdata[mo*DW +: DW];
  endfunction
  function automatic logic [IW-1:0] exp_tid();
    if (mo < 0) return '0;
    return s_tid[mo*IW +: IW];
  endfunction
  function automatic logic exp_bit(logic [N-1:0] v);
    if (mo < 0) return 1'b0;
    return v[mo];
  endfunction
  function automatic logic [N*CW-1:0] exp_cnt();
    logic [N*CW-1:0] v;
    for (int c = 0; c < N; c++) v[c*CW +: CW] = CW'(mc[c]);
    return v;
  endfunction
  // randomized packet sources: left = beats remaining in the current packet
  int left [N];
  int npct = 0, vpct = 100, plen = 0;
  task automatic src_step();
    for (int c = 0; c < N; c++) begin
      if (hs[c]) begin
        left[c]--;
        s_tdata[c*DW +: DW] = $urandom;
        s_tid[c*IW +: IW] = IW'($urandom);
        if (left[c] == 0) req[c] = 1'b0;
      end
      if (left[c] == 0 && $urandom_range(99) < npct) begin
        left[c] = (plen > 0) ? plen : $urandom_range(4, 1);
        req[c] = 1'b1;
      end
      s_tvalid[c] = (left[c] > 0) && ($urandom_range(99) < vpct);
      s_tlast[c] = (left[c] == 1);
    end
  endtask
  task automatic reset_dut();
    rst_n = 1'b0; req = '0; s_tvalid = '0; s_tlast = '0; m_tready = 1'b0; npct = 0;
    for (int c = 0; c < N; c++) left[c] = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0; req = '1; s_tvalid = '1; m_tready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #2;
      checks++; if (grant !== '0) begin failures++; $display("FAIL reset_grant got=%b exp=%b", grant, 5'b0); end
      checks++; if (s_tready !== '0) begin failures++; $display("FAIL reset_tready got=%b exp=%b", s_tready, 5'b0); end
      checks++; if (m_tvalid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_valid_busy got=%b%b exp=00", m_tvalid, busy); end
    end
`ifdef ARB_PKT_CNT_EN
    checks++; if (pkt_cnt !== '0) begin failures++; $display("FAIL reset_cnt got=%h exp=0", pkt_cnt); end
`endif
    req = '0; s_tvalid = '0; m_tready = 1'b0;
    rst_n = 1'b1;
  endtask
  task automatic test_single();
    logic [DW-1:0] d [4];
    for (int b = 0; b < 4; b++) d[b] = $urandom;
    req = 5'b00100; s_tvalid = 5'b00100; s_tlast = '0; s_tdata[2*DW +: DW] = d[0]; m_tready = 1'b1;
    @(posedge clk); #1;
    checks++; if (grant !== 5'b00100) begin failures++; $display("FAIL single_grant got=%b exp=%b", grant, 5'b00100); end
    for (int b = 0; b < 4; b++) begin
      s_tdata[2*DW +: DW] = d[b]; s_tlast[2] = (b == 3); #1;
      checks++; if (m_tdata !== d[b] || m_tlast !== (b == 3)) begin failures++; $display("FAIL single_beat%0d got=%h/%b exp=%h/%b", b, m_tdata, m_tlast, d[b], b == 3); end
      checks++; if (s_tready !== 5'b00100) begin failures++; $display("FAIL single_tready got=%b exp=%b", s_tready, 5'b00100); end
      checks++; if (grant !== exp_grant()) begin failures++; $display("FAIL single_model got=%b exp=%b", grant, exp_grant()); end
      @(posedge clk); #1;
    end
    req = '0; s_tvalid = '0; s_tlast = '0;
    checks++; if (grant !== '0 || busy !== 1'b0) begin failures++; $display("FAIL single_release got=%b/%b exp=0/0", grant, busy); end
    req = '1; s_tvalid = '1; s_tlast = '1;
    @(posedge clk); #1;
    checks++; if (grant !== 5'b01000) begin failures++; $display("FAIL single_next_ptr got=%b exp=%b", grant, 5'b01000); end
    @(posedge clk); #1;
    req = '0; s_tvalid = '0; s_tlast = '0;
    checks++; if (grant !== '0) begin failures++; $display("FAIL single_beat_release got=%b exp=0", grant); end
  endtask
  task automatic test_all_request();
    int order [6];
    int at [6];
    int n = 0;
    logic [N-1:0] prev = '0;
    int exp_order [6] = '{0, 1, 2, 3, 4, 0};
    reset_dut();
    npct = 100; plen = 2; vpct = 100; m_tready = 1'b1;
    for (int k = 0; k < 60 && n < 6; k++) begin
      src_step(); #1;
      checks++; if (grant !== exp_grant() || m_tdata !== exp_data()) begin failures++; $display("FAIL all_model got=%b/%h exp=%b/%h", grant, m_tdata, exp_grant(), exp_data()); end
      if (grant != '0 && prev == '0) begin
        for (int c = 0; c < N; c++) if (grant[c]) order[n] = c;
        at[n] = k;
        n++;
      end
      prev = grant;
      @(posedge clk); #1;
    end
    checks++; if (n != 6) begin failures++; $display("FAIL all_timeout got=%0d exp=6 grants", n); end
    for (int i = 0; i < n; i++) begin
      checks++; if (order[i] != exp_order[i]) begin failures++; $display("FAIL all_order%0d got=%0d exp=%0d", i, order[i], exp_order[i]); end
      if (i > 0) begin
        checks++; if (at[i] - at[i-1] != 3) begin failures++; $display("FAIL all_gap%0d got=%0d exp=3", i, at[i] - at[i-1]); end
      end
    end
  endtask
  task automatic test_backpressure();
    logic [DW-1:0] d [2];
    logic tr [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int b = 0;
    reset_dut();
    d[0] = $urandom; d[1] = $urandom;
    req = 5'b00010; s_tvalid = '1; s_tlast = '0; s_tdata[DW +: DW] = d[0]; m_tready = 1'b1;
    @(posedge clk); #1;
    checks++; if (grant !== 5'b00010) begin failures++; $display("FAIL bp_grant got=%b exp=%b", grant, 5'b00010); end
    for (int k = 0; k < 4; k++) begin
      m_tready = tr[k]; s_tdata[DW +: DW] = d[b]; s_tlast[1] = (b == 1); #1;
      checks++; if (s_tready !== (tr[k] ? 5'b00010 : 5'b0)) begin failures++; $display("FAIL bp_tready%0d got=%b exp=%b", k, s_tready, tr[k] ? 5'b00010 : 5'b0); end
      checks++; if (m_tdata !== d[b]) begin failures++; $display("FAIL bp_data%0d got=%h exp=%h", k, m_tdata, d[b]); end
      @(posedge clk); #1;
      if (tr[k]) b++;
    end
    req = '0; s_tvalid = '0; s_tlast = '0;
    checks++; if (grant !== '0) begin failures++; $display("FAIL bp_release got=%b exp=0", grant); end
  endtask
  task automatic test_lock_hold();
    reset_dut();
    m_tready = 1'b1; req = 5'b01000; s_tvalid = 5'b01000; s_tlast = '0;
    @(posedge clk); #1;
    checks++; if (grant !== 5'b01000) begin failures++; $display("FAIL lock_grant got=%b exp=%b", grant, 5'b01000); end
    @(posedge clk); #1;
    req = 5'b01001; s_tvalid = 5'b00001;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (grant !== 5'b01000 || m_tvalid !== 1'b0) begin failures++; $display("FAIL lock_hold%0d got=%b/%b exp=%b/0", k, grant, m_tvalid, 5'b01000); end
      @(posedge clk); #1;
    end
    s_tvalid = 5'b01001; s_tlast = 5'b01000; #1;
    checks++; if (grant !== 5'b01000 || m_tlast !== 1'b1) begin failures++; $display("FAIL lock_last got=%b/%b exp=%b/1", grant, m_tlast, 5'b01000); end
    @(posedge clk); #1;
    req = 5'b00001; s_tvalid = 5'b00001; s_tlast = '0; #1;
    checks++; if (grant !== '0) begin failures++; $display("FAIL lock_idle got=%b exp=0", grant); end
    @(posedge clk); #1;
    checks++; if (grant !== 5'b00001) begin failures++; $display("FAIL lock_next got=%b exp=%b", grant, 5'b00001); end
  endtask
  task automatic test_random();
    reset_dut();
    npct = 30; plen = 0; vpct = 75;
    for (int k = 0; k < 2000; k++) begin
      src_step(); m_tready = ($urandom_range(99) < 70); #1;
      checks++; if (grant !== exp_grant()) begin failures++; $display("FAIL rnd_grant cyc=%0d got=%b exp=%b", k, grant, exp_grant()); end
      checks++; if (s_tready !== (exp_grant() & {N{m_tready}})) begin failures++; $display("FAIL rnd_tready cyc=%0d got=%b exp=%b", k, s_tready, exp_grant() & {N{m_tready}}); end
      checks++; if ({m_tvalid, m_tlast, m_tid, m_tdata} !== {exp_bit(s_tvalid), exp_bit(s_tlast), exp_tid(), exp_data()}) begin failures++; $display("FAIL rnd_out cyc=%0d got=%b%b/%h/%h exp=%b%b/%h/%h", k, m_tvalid, m_tlast, m_tid, m_tdata, exp_bit(s_tvalid), exp_bit(s_tlast), exp_tid(), exp_data()); end
`ifdef ARB_PKT_CNT_EN
      checks++; if (pkt_cnt !== exp_cnt()) begin failures++; $display("FAIL rnd_cnt cyc=%0d got=%h exp=%h", k, pkt_cnt, exp_cnt()); end
`endif
      @(posedge clk); #1;
    end
  endtask
`ifdef ARB_PKT_CNT_EN
  task automatic test_pkt_cnt();
    int n = 0;
    reset_dut();
    req = 5'b10000; s_tvalid = 5'b10000; s_tlast = 5'b10000; m_tready = 1'b1;
    for (int k = 0; k < 40 && n < 5; k++) begin
      @(posedge clk); #1;
      if (hs[4]) n++;
    end
    req = '0; s_tvalid = '0; s_tlast = '0;
    checks++; if (n != 5) begin failures++; $display("FAIL cnt_timeout got=%0d exp=5 packets", n); end
    checks++; if (pkt_cnt[4*CW +: CW] !== CW'(3)) begin failures++; $display("FAIL cnt_sat got=%0d exp=3", pkt_cnt[4*CW +: CW]); end
    checks++; if (pkt_cnt !== exp_cnt()) begin failures++; $display("FAIL cnt_model got=%h exp=%h", pkt_cnt, exp_cnt()); end
    req = 5'b00010; s_tvalid = 5'b00010;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL cnt_lock got=%b exp=1", busy); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (grant !== '0 || pkt_cnt !== '0) begin failures++; $display("FAIL cnt_midreset got=%b/%h exp=0/0", grant, pkt_cnt); end
    req = '0; s_tvalid = '0;
  endtask
`endif
  initial begin
    for (int c = 0; c < N; c++) left[c] = 0;
    test_reset();
    test_single();
    test_all_request();
    test_backpressure();
    test_lock_hold();
    test_random();
`ifdef ARB_PKT_CNT_EN
    test_pkt_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
